cga_text_pixel: RTL

CGA_TEXT_PIXEL -- requirements
Module: cga_text_pixel

---
 rtl/cga_pkg.sv | 26 ++
 rtl/cga_delay.sv | 26 ++
 rtl/cga_text_pixel.sv | 108 ++++++++++
 3 files changed

// File: rtl/cga_pkg.sv
// cga_pkg: shared geometry, latency and address widths for the CGA text pixel pipeline
package cga_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;
    localparam int CELL_W   = 8;
    localparam int CELL_H   = 16;
    localparam int LATENCY  = 5;
    localparam int VRAM_AW  = 12;
    localparam int FONT_AW  = 12;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
    } attr_t;

    // Row times column count built from shifted partial products so no multiplier is inferred
    function automatic logic [VRAM_AW-1:0] mul_cols(input logic [5:0] row, input int cols);
        logic [VRAM_AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < VRAM_AW; i++)
            if (cols[i]) acc = acc + (VRAM_AW'(row) << i);
        return acc;
    endfunction

endpackage

// File: rtl/cga_delay.sv
// cga_delay: width x depth shift register used to keep side-band signals aligned with the pixel
module cga_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; reset empties every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/cga_text_pixel.sv
// cga_text_pixel: 80x30 text-mode pixel pipeline, 5-cycle latency; CGA_BLINK_EN enables attr[7] blink
module cga_text_pixel
    import cga_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int BLINK_BIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               de_i,
    input  logic               hs_i,
    input  logic               vs_i,
    input  logic [9:0]         x_i,
    input  logic [9:0]         y_i,
    output logic [VRAM_AW-1:0] vram_addr_o,
    input  logic [15:0]        vram_data_i,
    output logic [FONT_AW-1:0] font_addr_o,
    input  logic [7:0]         font_data_i,
    output logic [3:0]         color_o,
    output logic               de_o,
    output logic               hs_o,
    output logic               vs_o
);

    localparam int XS = $clog2(CELL_W);
    localparam int YS = $clog2(CELL_H);

    logic [5:0] row;
    logic [6:0] col;
    logic       in_range;
    logic       vis;
    logic       vis_d;
    logic [2:0] xb_d;
    logic [3:0] line_d;
    attr_t      attr_d;
    logic [3:0] fg;
    logic [3:0] bg;

    assign row      = y_i[9:YS];
    assign col      = x_i[9:XS];
    assign in_range = (int'(row) < ROWS) && (int'(col) < COLS);
    assign vis      = de_i & in_range;

    // Cell address from the current pixel; off-screen cells read address 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vram_addr_o <= '0;
        else         vram_addr_o <= in_range ? mul_cols(row, COLS) + VRAM_AW'(col) : '0;
    end

    cga_delay #(.WIDTH(3), .DEPTH(LATENCY)) u_sync (
        .clk(clk_i), .rst_n(rst_ni),
        .din({de_i, hs_i, vs_i}), .dout({de_o, hs_o, vs_o})
    );

    cga_delay #(.WIDTH(4), .DEPTH(LATENCY-1)) u_pix (
        .clk(clk_i), .rst_n(rst_ni),
        .din({vis, x_i[XS-1:0]}), .dout({vis_d, xb_d})
    );

    cga_delay #(.WIDTH(4), .DEPTH(2)) u_line (
        .clk(clk_i), .rst_n(rst_ni),
        .din(y_i[YS-1:0]), .dout(line_d)
    );

    cga_delay #(.WIDTH(8), .DEPTH(2)) u_attr (
        .clk(clk_i), .rst_n(rst_ni),
        .din(vram_data_i[15:8]), .dout(attr_d)
    );

    // Glyph row address from the fetched character and the line within the cell
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) font_addr_o <= '0;
        else         font_addr_o <= {vram_data_i[7:0], line_d};
    end

`ifdef CGA_BLINK_EN
    logic [4:0] frame_cnt;
    logic       vs_q;

    // Count vs rising edges; one bit of the count sets the blink phase
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_q <= vs_i;
            if (vs_i & ~vs_q) frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign bg = {1'b0, attr_d.bg[2:0]};
    assign fg = (attr_d.bg[3] & frame_cnt[BLINK_BIT]) ? bg : attr_d.fg;
`else
    logic unused_blink;

    assign unused_blink = ^BLINK_BIT;
    assign bg           = attr_d.bg;
    assign fg           = attr_d.fg;
`endif

    // Pick the glyph bit for this column; blanking and off-screen cells give black
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) color_o <= '0;
        else         color_o <= vis_d ? (font_data_i[~xb_d] ? fg : bg) : 4'h0;
    end

endmodule
